alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Requester side of the 8-bit ALU operand/result interface. Accepts one operation at a time on a valid/ready
//  request channel. Drives alu_a/alu_b/alu_ctrl to the external combinational ALU for SETTLE_CYCLES cycles.
//  Registers alu_result and returns it, with status flags, on a valid/ready response channel.
//  Sits between the instruction front-end and the ALU datapath.
// PARAMETERS
//  SETTLE_CYCLES  1   cycles alu_* are held stable before alu_result is sampled (legal 1..15)
//  TAG_W          4   width of request tag echoed on response
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous, active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      block can accept request
//  req_a        in   8      operand A
//  req_b        in   8      operand B
//  req_op       in   4      ALU opcode (package enum)
//  req_tag      in   TAG_W  caller tag
//  alu_a        out  8      operand A to ALU
//  alu_b        out  8      operand B to ALU
//  alu_ctrl     out  4      opcode to ALU
//  alu_result   in   16     combinational ALU result
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      consumer accepts response
//  rsp_result   out  16     captured result
//  rsp_tag      out  TAG_W  echoed req_tag
//  rsp_zero     out  1      rsp_result == 16'h0000
//  rsp_dz       out  1      divide attempted with B == 0
//  op_count     out  16     completed responses, wraps FFFF->0000
// BEHAVIOUR
//  - Reset (rst_n low at a rising edge):
//    - state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_tag=0; rsp_zero=0; rsp_dz=0; op_count=0.
//    - alu_a=0, alu_b=0, alu_ctrl=OP_NOP (4'hF).
//  - FSM states: IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE:
//    - req_ready=1.
//    - On req_valid&&req_ready, latch a/b/op/tag, load settle counter with SETTLE_CYCLES-1, go to ISSUE.
//  - ISSUE:
//    - req_ready=0; alu_a/alu_b/alu_ctrl = latched values, stable for exactly SETTLE_CYCLES cycles.
//    - In the last ISSUE cycle (counter==0), register alu_result into rsp_result.
//    - Same edge: set rsp_zero and rsp_dz (op==OP_DIV && b==0), set rsp_tag, go to RESP.
//  - RESP:
//    - rsp_valid=1; all rsp_* held stable until rsp_ready.
//    - On rsp_valid&&rsp_ready: op_count+1 (mod 2^16), rsp_valid drops next cycle, go to IDLE.
//  - Outside ISSUE: alu_a=alu_b=0 and alu_ctrl=OP_NOP.
//  - Latency: rsp_valid rises SETTLE_CYCLES+1 edges after the accepting edge. Minimum spacing between accepts is
//    SETTLE_CYCLES+2 cycles.
//  - No accept during RESP, even when rsp_ready is high. Requests are never dropped; the requester holds them
//    while req_ready=0.
//  - Width rules:
//    - alu_result is taken verbatim as 16 bits.
//    - Flags derive only from the captured value and latched operands, never from live alu_result.
//  - Reset mid-operation (ISSUE or RESP): the transaction is discarded with no response and op_count=0.
//  - op_count wrap: FFFF + handshake -> 0000; no sticky overflow.
//  - Request inputs changing while req_ready=0 are ignored.
// STRUCTURE
//  - Package alu_pkg holds:
//    - alu_op_e, the 4-bit opcode enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOTA=5, INC=6, DEC=7, SHL=8, SHR=9,
//      NOTA2=A, NOTB=B, MUL=C, DIV=D, EQ=E, NOP=F.
//    - seq_state_e, the FSM state enum.
//    - Constants ALU_OPW=4, ALU_DW=8, ALU_RW=16.
//  - Single flat module, no sub-module. The ALU is instantiated beside this block by the parent, not inside it.
// TESTING
//  - Reset: rst_n=0 for 2 cycles -> req_ready=1, rsp_valid=0, alu_ctrl=4'hF, op_count=0.
//  - ADD: a=8'hFF, b=8'h01, op=0, tag=3 (SETTLE=1), ALU model -> rsp_result=16'h0100, zero=0, tag=3,
//    rsp_valid 2 edges after accept.
//  - DIV by zero: a=8'h20, b=0, op=D -> rsp_result=0, rsp_zero=1, rsp_dz=1; a=8'h20, b=4 -> 16'h0008, dz=0.
//  - Backpressure: hold rsp_ready=0 for 5 cycles after MUL a=8'h10 b=8'h10 -> rsp_result=16'h0100 stable,
//    req_ready=0 throughout, op_count unchanged until handshake.
//  - Reset mid-ISSUE with SETTLE=3, asserted in the 2nd ISSUE cycle -> no rsp_valid, IDLE next cycle, op_count=0.
//  - Wrap: force op_count to 16'hFFFF via 65535 ops, or a bench preload, then one more op -> op_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and width definitions for the ALU
// operand/result sequencer.
package alu_pkg;

  localparam int ALU_OPW = 4;
  localparam int ALU_DW  = 8;
  localparam int ALU_RW  = 16;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOTA  = 4'h5,
    OP_INC   = 4'h6,
    OP_DEC   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_NOTA2 = 4'hA,
    OP_NOTB  = 4'hB,
    OP_MUL   = 4'hC,
    OP_DIV   = 4'hD,
    OP_EQ    = 4'hE,
    OP_NOP   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Requester side of the ALU interface: issues one op, holds operands
// for SETTLE_CYCLES, captures the result and returns it with flags.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ALU_DW-1:0] req_a,
  input  logic [ALU_DW-1:0] req_b,
  input  logic [ALU_OPW-1:0] req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [ALU_DW-1:0] alu_a,
  output logic [ALU_DW-1:0] alu_b,
  output logic [ALU_OPW-1:0] alu_ctrl,
  input  logic [ALU_RW-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ALU_RW-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_zero,
  output logic              rsp_dz,
  output logic [15:0]       op_count
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [ALU_DW-1:0] a_q, a_d;
  logic [ALU_DW-1:0] b_q, b_d;
  alu_op_e           op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ALU_RW-1:0] res_q, res_d;
  logic [TAG_W-1:0]  rtag_q, rtag_d;
  logic              zero_q, zero_d;
  logic              dz_q, dz_d;
  logic [15:0]       op_count_q, op_count_d;

  logic accept, capture, handshake;

  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign capture   = (state_q == ST_ISSUE) && (cnt_q == 4'd0);
  assign handshake = (state_q == ST_RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_NOP;
      tag_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      rtag_q     <= '0;
      zero_q     <= 1'b0;
      dz_q       <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      rtag_q     <= rtag_d;
      zero_q     <= zero_d;
      dz_q       <= dz_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    rtag_d     = rtag_q;
    zero_d     = zero_q;
    dz_d       = dz_q;
    op_count_d = op_count_q;
    if (accept) begin
      a_d   = req_a;
      b_d   = req_b;
      op_d  = alu_op_e'(req_op);
      tag_d = req_tag;
      cnt_d = CNT_LOAD;
    end
    if ((state_q == ST_ISSUE) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    // Flags come from the value being captured and the latched operands.
    if (capture) begin
      res_d  = alu_result;
      zero_d = (alu_result == '0);
      dz_d   = (op_q == OP_DIV) && (b_q == '0);
      rtag_d = tag_q;
    end
    if (handshake) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = OP_NOP;
    if (state_q == ST_ISSUE) begin
      alu_a    = a_q;
      alu_b    = b_q;
      alu_ctrl = op_q;
    end
  end

  assign rsp_result = res_q;
  assign rsp_tag    = rtag_q;
  assign rsp_zero   = zero_q;
  assign rsp_dz     = dz_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (settle 1 and 3) each driving a
// behavioural combinational ALU.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] op
  );
    logic [15:0] r;
    r = 16'h0;
    case (op)
      4'h0: r = {8'h0, a} + {8'h0, b};
      4'h1: r = {8'h0, a} - {8'h0, b};
      4'h2: r = {8'h0, a & b};
      4'h3: r = {8'h0, a | b};
      4'hC: r = {8'h0, a} * {8'h0, b};
      4'hD: r = (b == 8'h0) ? 16'h0 : {8'h0, a / b};
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  // settle = 1 instance
  logic       rst1_n;
  logic       v1, rdy1, rr1;
  logic [7:0] a1, b1;
  logic [3:0] op1, tag1;
  logic [7:0] alu_a1, alu_b1;
  logic [3:0] alu_c1;
  logic [15:0] alu_r1;
  logic        rv1;
  logic [15:0] res1;
  logic [3:0]  rtag1;
  logic        z1, dz1;
  logic [15:0] cnt1;

  assign alu_r1 = alu_f(alu_a1, alu_b1, alu_c1);

  alu_op_sequencer #(.SETTLE_CYCLES(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .req_valid(v1), .req_ready(rdy1),
    .req_a(a1), .req_b(b1), .req_op(op1), .req_tag(tag1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_c1),
    .alu_result(alu_r1),
    .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_result(res1), .rsp_tag(rtag1),
    .rsp_zero(z1), .rsp_dz(dz1), .op_count(cnt1)
  );

  // settle = 3 instance
  logic       rst3_n;
  logic       v3, rdy3, rr3;
  logic [7:0] a3, b3;
  logic [3:0] op3, tag3;
  logic [7:0] alu_a3, alu_b3;
  logic [3:0] alu_c3;
  logic [15:0] alu_r3;
  logic        rv3;
  logic [15:0] res3;
  logic [3:0]  rtag3;
  logic        z3, dz3;
  logic [15:0] cnt3;

  assign alu_r3 = alu_f(alu_a3, alu_b3, alu_c3);

  alu_op_sequencer #(.SETTLE_CYCLES(3), .TAG_W(4)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .req_valid(v3), .req_ready(rdy3),
    .req_a(a3), .req_b(b3), .req_op(op3), .req_tag(tag3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(alu_c3),
    .alu_result(alu_r3),
    .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_result(res3), .rsp_tag(rtag3),
    .rsp_zero(z3), .rsp_dz(dz3), .op_count(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one request to dut1, then wait (bounded) for its response.
  task automatic issue1(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
    bit seen;
    v1 = 1'b1; a1 = a; b1 = b; op1 = op; tag1 = tag;
    step();
    v1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rv1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("rsp1_timeout", 32'(seen), 32'd1);
  endtask

  task automatic hs1();
    rr1 = 1'b1;
    step();
    rr1 = 1'b0;
  endtask

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; op1 = 0; tag1 = 0; rr1 = 0;
    v3 = 0; a3 = 0; b3 = 0; op3 = 0; tag3 = 0; rr3 = 0;
    @(negedge clk);
    step();
    step();
    chk("rst_req_ready", 32'(rdy1), 32'd1);
    chk("rst_rsp_valid", 32'(rv1), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_c1), 32'hF);
    chk("rst_alu_a", 32'(alu_a1), 32'h0);
    chk("rst_op_count", 32'(cnt1), 32'h0);
    chk("rst_rsp_result", 32'(res1), 32'h0);
    rst1_n = 1'b1; rst3_n = 1'b1;
    step();

    // ADD with explicit latency checks
    v1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; op1 = 4'h0; tag1 = 4'd3;
    rr1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("add_issue_valid", 32'(rv1), 32'd0);
    chk("add_issue_ready", 32'(rdy1), 32'd0);
    chk("add_alu_a", 32'(alu_a1), 32'hFF);
    chk("add_alu_ctrl", 32'(alu_c1), 32'h0);
    step();
    chk("add_rsp_valid", 32'(rv1), 32'd1);
    chk("add_result", 32'(res1), 32'h0100);
    chk("add_zero", 32'(z1), 32'd0);
    chk("add_tag", 32'(rtag1), 32'd3);
    chk("add_alu_idle", 32'(alu_c1), 32'hF);
    step();
    rr1 = 1'b0;
    chk("add_valid_drop", 32'(rv1), 32'd0);
    chk("add_count", 32'(cnt1), 32'd1);
    chk("add_ready_back", 32'(rdy1), 32'd1);

    // divide by zero, then a legal divide
    issue1(8'h20, 8'h00, 4'hD, 4'd5);
    chk("div0_result", 32'(res1), 32'h0);
    chk("div0_zero", 32'(z1), 32'd1);
    chk("div0_dz", 32'(dz1), 32'd1);
    chk("div0_tag", 32'(rtag1), 32'd5);
    hs1();
    issue1(8'h20, 8'h04, 4'hD, 4'd6);
    chk("div_result", 32'(res1), 32'h0008);
    chk("div_zero", 32'(z1), 32'd0);
    chk("div_dz", 32'(dz1), 32'd0);
    hs1();
    chk("div_count", 32'(cnt1), 32'd3);

    // backpressure with a new request waiting behind it
    issue1(8'h10, 8'h10, 4'hC, 4'd7);
    v1 = 1'b1; a1 = 8'h01; b1 = 8'h01; op1 = 4'h0; tag1 = 4'd8;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(rv1), 32'd1);
      chk("bp_result", 32'(res1), 32'h0100);
      chk("bp_tag", 32'(rtag1), 32'd7);
      chk("bp_ready", 32'(rdy1), 32'd0);
      chk("bp_count", 32'(cnt1), 32'd3);
    end
    rr1 = 1'b1;
    step();
    rr1 = 1'b0;
    chk("bp_hs_count", 32'(cnt1), 32'd4);
    chk("bp_hs_valid", 32'(rv1), 32'd0);
    chk("bp_hs_ready", 32'(rdy1), 32'd1);
    step();
    v1 = 1'b0;
    chk("held_req_accepted", 32'(rdy1), 32'd0);
    step();
    chk("held_valid", 32'(rv1), 32'd1);
    chk("held_result", 32'(res1), 32'h0002);
    chk("held_tag", 32'(rtag1), 32'd8);
    hs1();
    chk("held_count", 32'(cnt1), 32'd5);

    // op_count wrap via preload
    force dut1.op_count_q = 16'hFFFF;
    #1;
    release dut1.op_count_q;
    @(negedge clk);
    chk("wrap_preload", 32'(cnt1), 32'hFFFF);
    issue1(8'h00, 8'h00, 4'h0, 4'd9);
    chk("wrap_zero_flag", 32'(z1), 32'd1);
    chk("wrap_pre_hs", 32'(cnt1), 32'hFFFF);
    hs1();
    chk("wrap_count", 32'(cnt1), 32'h0);

    // settle = 3: operands stable for 3 cycles, response on 4th edge
    v3 = 1'b1; a3 = 8'h02; b3 = 8'h03; op3 = 4'h0; tag3 = 4'd1;
    rr3 = 1'b1;
    step();
    v3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s3_alu_a", 32'(alu_a3), 32'h02);
      chk("s3_alu_b", 32'(alu_b3), 32'h03);
      chk("s3_alu_ctrl", 32'(alu_c3), 32'h0);
      chk("s3_no_valid", 32'(rv3), 32'd0);
      step();
    end
    chk("s3_valid", 32'(rv3), 32'd1);
    chk("s3_result", 32'(res3), 32'h0005);
    step();
    chk("s3_count", 32'(cnt3), 32'd1);

    // reset in the second ISSUE cycle discards the transaction
    v3 = 1'b1; a3 = 8'h07; b3 = 8'h01; op3 = 4'h0; tag3 = 4'd2;
    step();
    v3 = 1'b0;
    step();
    chk("mid_in_issue", 32'(alu_a3), 32'h07);
    rst3_n = 1'b0;
    step();
    rst3_n = 1'b1;
    chk("mid_rst_ready", 32'(rdy3), 32'd1);
    chk("mid_rst_valid", 32'(rv3), 32'd0);
    chk("mid_rst_count", 32'(cnt3), 32'd0);
    chk("mid_rst_ctrl", 32'(alu_c3), 32'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_rsp", 32'(rv3), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
